mul_shift_block: RTL and testbench
==================================

# mul_shift_block

Partial-product generator for the shift-and-add multiplier datapath. Each instance owns one bit position `index` of multiplier `in_b`. It emits `in_a` shifted left by `index` when that multiplier bit is 1, and zero otherwise. One instance per multiplier bit runs in parallel; the downstream adder sums their `res` outputs directly, with no further shifting, to form `in_a * in_b`.

## Interface
Parameters:
- `A_W`, default 4: width of multiplicand `in_a`.
- `B_W`, default 4: width of multiplier `in_b`.
- `IDX_W`, default 4: width of `index`.
- `OUT_W`, default 32: width of `res`. Must be at least `A_W + B_W - 1`.

Ports:
- `CLK`, input, 1: the single clock. All state updates on the rising edge.
- `RST`, input, 1: reset, synchronous and active-high.
- `index`, input, `IDX_W`: multiplier bit position this instance handles. Normally tied to a constant.
- `in_a`, input, `A_W`: multiplicand, unsigned.
- `in_b`, input, `B_W`: multiplier, unsigned.
- `res`, output, `OUT_W`: registered partial product.

## Operation
- Combinational next value:
  - `pp = in_b[index] ? (zero-extend(in_a) << index) : 0`.
  - Computed at `OUT_W` bits.
- Bit select:
  - If `index >= B_W`, the selected bit is 0, so `pp = 0`. Never index out of range.
- Shift:
  - Logical left shift; zeros fill from the LSB.
  - Bits shifted past `OUT_W-1` are discarded.
  - With default parameters no truncation occurs (max 15<<3 = 120).
- Arithmetic is unsigned only. There is no sign extension.
- `index`, `in_a` and `in_b` may all change every cycle. No handshake; the block is free-running.
- Summing `res` across instances with `index` = 0..B_W-1 yields the full product `in_a * in_b`, truncated to `OUT_W` bits.
- Elaboration error if `OUT_W < A_W + B_W - 1` or `IDX_W < clog2(B_W)`.

## Timing
- `res` is a register loaded on every rising `CLK` edge with `pp` from the inputs sampled at that edge.
- Latency is 1 cycle; throughput is one result per cycle.
- Reset:
  - When `RST` = 1 at a rising edge, `res` becomes 0, overriding `pp`.
  - Reset value of `res` is 0.
  - Reset asserted mid-stream discards the in-flight value.
  - The first edge after `RST` deasserts loads a normal `pp`.
- Before the first edge and with no reset, `res` is undefined. Users assert `RST` or wait one edge.
- No combinational path from any input to `res`.

## Test plan
- Four instances with `index` 0..3, `in_a`=8, `in_b`=9, one edge later:
  - `res` = 8, 0, 0, 64.
  - Sum = 72.
- Exhaustive 4-bit sweep of `in_a` × `in_b` across four instances: the sum of `res` one cycle after each input change equals `in_a*in_b`, e.g. 15*15 = 225.
- `index`=3, `in_a`=15, `in_b`=8 gives `res`=120. Changing to `in_b`=7 gives `res`=0 on the next edge.
- `index`=5 (≥ `B_W`), `in_b`=15, `in_a`=15 gives `res`=0.
- Reset:
  - `res`=64, then assert `RST` for one edge: `res`=0 immediately after that edge.
  - Deassert `RST` with inputs unchanged: `res`=64 after the next edge.
- Inputs change between edges: `res` holds its value until the next rising edge, with no glitch.

Source files
------------

// File: rtl/mul_shift_block.sv
// Partial-product generator for a shift-and-add multiplier: one instance per
// multiplier bit, emitting in_a << index when in_b[index] is set, registered.
module mul_shift_block #(
  parameter int A_W   = 4,
  parameter int B_W   = 4,
  parameter int IDX_W = 4,
  parameter int OUT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [IDX_W-1:0] index,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  output logic [OUT_W-1:0] res
);

  if (OUT_W < A_W + B_W - 1) begin : g_bad_out_w
    $error("mul_shift_block: OUT_W must be at least A_W + B_W - 1");
  end

  if (IDX_W < $clog2(B_W)) begin : g_bad_idx_w
    $error("mul_shift_block: IDX_W too narrow to address every bit of in_b");
  end

  logic             bit_sel_s;
  logic [OUT_W-1:0] pp_d;
  logic [OUT_W-1:0] res_q;

  // Multiplier bit select; an index at or beyond B_W matches no bit and yields 0.
  always_comb begin
    bit_sel_s = 1'b0;
    for (int i = 0; i < B_W; i++) begin
      bit_sel_s = bit_sel_s | ((index == IDX_W'(i)) & in_b[i]);
    end
  end

  // Zero-extended multiplicand shifted into place; overflow past OUT_W is dropped.
  always_comb begin
    if (bit_sel_s) begin
      pp_d = OUT_W'(in_a) << index;
    end else begin
      pp_d = {OUT_W{1'b0}};
    end
  end

  // Result register; reset wins over the freshly computed partial product.
  always_ff @(posedge CLK) begin
    if (RST) begin
      res_q <= {OUT_W{1'b0}};
    end else begin
      res_q <= pp_d;
    end
  end

  assign res = res_q;

endmodule

// File: tb/tb_mul_shift_block.sv
// Self-checking bench: four fixed-index instances forming a full 4x4 product
// plus one instance with a driven index, checked against an arithmetic model.
module tb_mul_shift_block;

  logic        CLK;
  logic        RST;
  logic [3:0]  in_a;
  logic [3:0]  in_b;
  logic [3:0]  idx_var;
  logic [31:0] res_fix [4];
  logic [31:0] res_var;

  int n_cmp;
  int n_err;

  for (genvar gi = 0; gi < 4; gi++) begin : g_fix
    mul_shift_block #(.A_W(4), .B_W(4), .IDX_W(4), .OUT_W(32)) u_fix (
      .CLK   (CLK),
      .RST   (RST),
      .index (4'(gi)),
      .in_a  (in_a),
      .in_b  (in_b),
      .res   (res_fix[gi])
    );
  end

  mul_shift_block #(.A_W(4), .B_W(4), .IDX_W(4), .OUT_W(32)) u_var (
    .CLK   (CLK),
    .RST   (RST),
    .index (idx_var),
    .in_a  (in_a),
    .in_b  (in_b),
    .res   (res_var)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    int          a;
    int          b;
    int          idx;
    logic [31:0] r [4];
    logic [31:0] rv;
    logic [31:0] sum;
  } vec_t;

  vec_t vecs [8];

  // Reference: product bit idx of b times a scaled by 2**idx; zero beyond B_W.
  function automatic logic [31:0] ref_pp(input int a, input int b, input int idx);
    if (idx >= 4) return 32'd0;
    if (((b / (2 ** idx)) % 2) == 1) return 32'(a * (2 ** idx));
    return 32'd0;
  endfunction

  function automatic logic [31:0] fix_sum();
    return res_fix[0] + res_fix[1] + res_fix[2] + res_fix[3];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input int a, input int b, input int idx);
    in_a    = 4'(a);
    in_b    = 4'(b);
    idx_var = 4'(idx);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    RST = 1'b1;
    drive(15, 15, 2);

    vecs[0] = '{"a8_b9",    8,  9, 3, '{32'd8,  32'd0,  32'd0,  32'd64},  32'd64,  32'd72};
    vecs[1] = '{"a15_b15", 15, 15, 1, '{32'd15, 32'd30, 32'd60, 32'd120}, 32'd30,  32'd225};
    vecs[2] = '{"a15_b8",  15,  8, 3, '{32'd0,  32'd0,  32'd0,  32'd120}, 32'd120, 32'd120};
    vecs[3] = '{"a15_b7",  15,  7, 3, '{32'd15, 32'd30, 32'd60, 32'd0},   32'd0,   32'd105};
    vecs[4] = '{"idx5",    15, 15, 5, '{32'd15, 32'd30, 32'd60, 32'd120}, 32'd0,   32'd225};
    vecs[5] = '{"a0",       0, 15, 2, '{32'd0,  32'd0,  32'd0,  32'd0},   32'd0,   32'd0};
    vecs[6] = '{"a5_b10",   5, 10, 1, '{32'd0,  32'd10, 32'd0,  32'd40},  32'd10,  32'd50};
    vecs[7] = '{"idx15",    1,  1, 15, '{32'd1, 32'd0,  32'd0,  32'd0},   32'd0,   32'd1};

    step();
    step();
    for (int i = 0; i < 4; i++) check($sformatf("reset_fix%0d", i), res_fix[i], 32'd0);
    check("reset_var", res_var, 32'd0);
    RST = 1'b0;

    // Table of hand-derived vectors
    for (int v = 0; v < 8; v++) begin
      drive(vecs[v].a, vecs[v].b, vecs[v].idx);
      step();
      for (int i = 0; i < 4; i++)
        check($sformatf("%s_fix%0d", vecs[v].name, i), res_fix[i], vecs[v].r[i]);
      check($sformatf("%s_var", vecs[v].name), res_var, vecs[v].rv);
      check($sformatf("%s_sum", vecs[v].name), fix_sum(), vecs[v].sum);
    end

    // Mid-stream reset discards the value, release reloads it
    drive(8, 9, 3);
    step();
    check("pre_rst", res_var, 32'd64);
    RST = 1'b1;
    step();
    check("rst_var", res_var, 32'd0);
    check("rst_sum", fix_sum(), 32'd0);
    RST = 1'b0;
    step();
    check("post_rst_var", res_var, 32'd64);
    check("post_rst_sum", fix_sum(), 32'd72);

    // Inputs changing between edges must not reach res before the edge
    drive(15, 15, 3);
    #2;
    check("hold_var", res_var, 32'd64);
    check("hold_sum", fix_sum(), 32'd72);
    drive(7, 12, 2);
    #1;
    check("hold2_var", res_var, 32'd64);
    step();
    check("after_hold_var", res_var, 32'd28);
    check("after_hold_sum", fix_sum(), 32'd84);

    // Exhaustive a x b sweep with a random index on the variable instance
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        int idx;
        idx = int'($urandom_range(0, 15));
        drive(a, b, idx);
        step();
        check($sformatf("sweep_sum_%0dx%0d", a, b), fix_sum(), 32'(a * b));
        check($sformatf("sweep_var_%0dx%0d_i%0d", a, b, idx), res_var, ref_pp(a, b, idx));
      end
    end

    // Random stream with occasional reset pulses
    for (int n = 0; n < 300; n++) begin
      int a, b, idx;
      logic r;
      a   = int'($urandom_range(0, 15));
      b   = int'($urandom_range(0, 15));
      idx = int'($urandom_range(0, 15));
      r   = ($urandom_range(0, 19) == 0);
      RST = r;
      drive(a, b, idx);
      step();
      check($sformatf("rnd%0d_var", n), res_var, r ? 32'd0 : ref_pp(a, b, idx));
      for (int i = 0; i < 4; i++)
        check($sformatf("rnd%0d_fix%0d", n, i), res_fix[i], r ? 32'd0 : ref_pp(a, b, i));
    end
    RST = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
